// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared state encodings and 8-bit K-character constants for the deserialiser
package serdes_pkg;

    // Word-alignment state machine encoding
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // 8-bit K-character values (8b/10b control symbols)
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;
    localparam logic [7:0] FTS = 8'h3C;
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;

    // Width of the consecutive-comma counter; holds LOCK_COUNT values up to 15
    localparam int CCNT_W = 4;

endpackage

// File: rtl/detector_com.sv
// rtl/detector_com.sv - combinational comma match on the candidate next word
module detector_com #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] COM_CHAR = WIDTH'(8'hBC)
)(
    input  logic [WIDTH-1:0] i_word,
    output logic             o_match
);

    assign o_match = (i_word == COM_CHAR);

endmodule

// File: rtl/deserializador_sync.sv
// rtl/deserializador_sync.sv - serial-to-parallel deserialiser with comma-based word alignment and lock
module deserializador_sync
    import serdes_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_CHAR   = WIDTH'(COM),
    parameter int               LOCK_COUNT = 2
)(
    input  logic             clk,
    input  logic             reset_L,
    input  logic             data,
    input  logic             DK,
    output logic [WIDTH-1:0] out,
    output logic             out_DK,
    output logic             valid,
    output logic             locked
);

    localparam int                 BCNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCNT_W-1:0]  LAST_BIT = BCNT_W'(WIDTH - 1);
    localparam logic [CCNT_W-1:0]  LOCK_CNT = CCNT_W'(LOCK_COUNT);

    // Only the newest WIDTH-1 bits are kept: the oldest bit of the shift
    // register falls off on the very edge the new bit enters, so it is never read.
    logic [WIDTH-2:0]  r_sr;
    logic [BCNT_W-1:0] r_bcnt;
    logic [CCNT_W-1:0] r_ccnt;
    sync_state_t       r_state;
    logic [WIDTH-1:0]  r_out;
    logic              r_out_dk;
    logic              r_valid;

    logic [WIDTH-1:0]  w_nw;
    logic              w_com;
    logic              w_boundary;
    sync_state_t       w_state_nxt;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic [CCNT_W-1:0] w_ccnt_nxt;
    logic [CCNT_W-1:0] w_ccnt_inc;
    logic              w_emit;

    assign w_nw       = {r_sr, data};
    assign w_boundary = (r_bcnt == LAST_BIT);

    detector_com #(
        .WIDTH    (WIDTH),
        .COM_CHAR (COM_CHAR)
    ) u_detector_com (
        .i_word  (w_nw),
        .o_match (w_com)
    );

    // Next-state, counter and emit decisions for the alignment state machine
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = w_boundary ? '0 : r_bcnt + BCNT_W'(1);
        w_ccnt_nxt  = r_ccnt;
        w_emit      = 1'b0;
        w_ccnt_inc  = (r_ccnt >= LOCK_CNT) ? LOCK_CNT : r_ccnt + CCNT_W'(1);

        unique case (r_state)
            HUNT: begin
                if (w_com) begin
                    // A comma anywhere sets word phase: next bit is bit 0 of a word
                    w_bcnt_nxt = '0;
                    w_ccnt_nxt = CCNT_W'(1);
                    if (LOCK_COUNT == 1) begin
                        w_state_nxt = LOCKED;
                        w_emit      = 1'b1;
                    end else begin
                        w_state_nxt = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_com) begin
                        w_ccnt_nxt = w_ccnt_inc;
                        if (w_ccnt_inc >= LOCK_CNT) begin
                            // The comma that completes the count is the first locked word
                            w_state_nxt = LOCKED;
                            w_emit      = 1'b1;
                        end
                    end else begin
                        w_state_nxt = HUNT;
                        w_ccnt_nxt  = '0;
                    end
                end else if (w_com) begin
                    // Comma at a different phase: restart counting from this one
                    w_bcnt_nxt = '0;
                    w_ccnt_nxt = CCNT_W'(1);
                end
            end
            LOCKED: begin
                if (w_boundary) begin
                    w_emit = 1'b1;
                end else if (w_com) begin
                    // Misaligned comma means the phase slipped; re-align on it
                    w_state_nxt = ALIGN;
                    w_bcnt_nxt  = '0;
                    w_ccnt_nxt  = CCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_bcnt_nxt  = '0;
                w_ccnt_nxt  = '0;
            end
        endcase
    end

    // Shift register, bit counter, comma counter and state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_sr    <= '0;
            r_bcnt  <= '0;
            r_ccnt  <= '0;
            r_state <= HUNT;
        end else begin
            r_sr    <= w_nw[WIDTH-2:0];
            r_bcnt  <= w_bcnt_nxt;
            r_ccnt  <= w_ccnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Output word register: captures the word and its DK flag on emit edges, holds otherwise
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_out    <= '0;
            r_out_dk <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_out    <= w_nw;
                r_out_dk <= DK;
            end
        end
    end

    assign out    = r_out;
    assign out_DK = r_out_dk;
    assign valid  = r_valid;
    assign locked = (r_state == LOCKED);

endmodule

// File: tb/tb_deserializador_sync.sv
// tb/tb_deserializador_sync.sv - self-checking bench for deserializador_sync (8-bit and 10-bit instances)
module tb_deserializador_sync;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       d8, k8, d10, k10;
    logic [7:0] out8;
    logic       dk8, v8, l8;
    logic [9:0] out10;
    logic       dk10, v10, l10;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    deserializador_sync #(.WIDTH(8), .COM_CHAR(8'hBC), .LOCK_COUNT(2)) dut8 (
        .clk(clk), .reset_L(reset_L), .data(d8), .DK(k8),
        .out(out8), .out_DK(dk8), .valid(v8), .locked(l8)
    );

    deserializador_sync #(.WIDTH(10), .COM_CHAR(10'h17C), .LOCK_COUNT(1)) dut10 (
        .clk(clk), .reset_L(reset_L), .data(d10), .DK(k10),
        .out(out10), .out_DK(dk10), .valid(v10), .locked(l10)
    );

    logic [34:0] obs [2];
    always_comb begin
        obs[0] = {v8, l8, dk8, 24'd0, out8};
        obs[1] = {v10, l10, dk10, 22'd0, out10};
    end

    // Reference model: absolute bit history, word phase measured from the anchoring comma's time
    bit hist [2][0:8191];
    int m_t [2];
    int m_mode [2];
    int m_anchor [2];
    int m_hits [2];
    int m_out [2];
    bit m_dk [2];
    bit m_valid [2];

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_t[u] = 0; m_mode[u] = 0; m_anchor[u] = 0; m_hits[u] = 0;
            m_out[u] = 0; m_dk[u] = 1'b0; m_valid[u] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input int u, input bit d, input bit k);
        int w, lc, com_v, e, word;
        bit com, bnd;
        w     = (u == 1) ? 10 : 8;
        lc    = (u == 1) ? 1 : 2;
        com_v = (u == 1) ? 'h17C : 'hBC;
        e = m_t[u];
        hist[u][e] = d;
        m_t[u] = e + 1;
        word = 0;
        for (int i = 0; i < w; i++)
            if (e - i >= 0 && hist[u][e - i]) word += (1 << i);
        com = (word == com_v);
        bnd = (e > m_anchor[u]) && ((e - m_anchor[u]) % w == 0);
        m_valid[u] = 1'b0;
        if (m_mode[u] == 0) begin
            if (com) begin
                m_anchor[u] = e; m_hits[u] = 1;
                if (lc == 1) begin
                    m_mode[u] = 2; m_valid[u] = 1'b1; m_out[u] = word; m_dk[u] = k;
                end else m_mode[u] = 1;
            end
        end else if (m_mode[u] == 1) begin
            if (bnd) begin
                if (com) begin
                    m_hits[u] = (m_hits[u] + 1 > lc) ? lc : m_hits[u] + 1;
                    if (m_hits[u] >= lc) begin
                        m_mode[u] = 2; m_valid[u] = 1'b1; m_out[u] = word; m_dk[u] = k;
                    end
                end else begin
                    m_mode[u] = 0; m_hits[u] = 0;
                end
            end else if (com) begin
                m_anchor[u] = e; m_hits[u] = 1;
            end
        end else begin
            if (bnd) begin
                m_valid[u] = 1'b1; m_out[u] = word; m_dk[u] = k;
            end else if (com) begin
                m_anchor[u] = e; m_hits[u] = 1; m_mode[u] = 1;
            end
        end
    endfunction

    function automatic logic [34:0] exp_vec(input int u);
        return {m_valid[u], (m_mode[u] == 2), m_dk[u], 32'(m_out[u])};
    endfunction

    task automatic cycle(input bit a0, input bit b0, input bit a1, input bit b1);
        d8 = a0; k8 = b0; d10 = a1; k10 = b1;
        @(posedge clk);
        #1;
        model_edge(0, a0, b0);
        model_edge(1, a1, b1);
        cyc++;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        model_reset();
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (obs[u] !== 35'd0) begin
                errors++; $display("FAIL reset_async dut%0d got=%h exp=0", u, obs[u]);
            end
        end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs[u] !== exp_vec(u)) begin
                    errors++; $display("FAIL reset_run dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] wd [3];
        bit wk [3];
        int vt [$];
        logic [7:0] vo [$];
        bit vk [$];
        wd = '{8'hBC, 8'hBC, 8'h5A};
        wk = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int b = 7; b >= 0; b--) begin
                cycle(wd[i][b], wk[i], 1'($urandom), 1'($urandom));
                for (int u = 0; u < 2; u++) begin
                    checks++;
                    if (obs[u] !== exp_vec(u)) begin
                        errors++; $display("FAIL basic dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                    end
                end
                if (v8) begin vt.push_back(cyc); vo.push_back(out8); vk.push_back(dk8); end
                if (i == 1 && b == 1) begin
                    checks++;
                    if (l8 !== 1'b0) begin errors++; $display("FAIL basic_prelock got=%b exp=0", l8); end
                end
                if (i == 1 && b == 0) begin
                    checks++;
                    if (l8 !== 1'b1) begin errors++; $display("FAIL basic_lock got=%b exp=1", l8); end
                end
            end
        end
        checks++;
        if (vt.size() != 2) begin
            errors++; $display("FAIL basic_pulses got=%0d exp=2", vt.size());
        end else begin
            checks++;
            if ({vo[0], vk[0]} !== {8'hBC, 1'b1}) begin errors++; $display("FAIL basic_w0 got=%h/%b exp=bc/1", vo[0], vk[0]); end
            checks++;
            if ({vo[1], vk[1]} !== {8'h5A, 1'b0}) begin errors++; $display("FAIL basic_w1 got=%h/%b exp=5a/0", vo[1], vk[1]); end
            checks++;
            if (vt[1] - vt[0] != 8) begin errors++; $display("FAIL basic_period got=%0d exp=8", vt[1] - vt[0]); end
        end
    endtask

    task automatic test_offset();
        logic [7:0] wd [3];
        int vt [$];
        logic [7:0] vo [$];
        int c0;
        wd = '{8'hBC, 8'hBC, 8'hA5};
        do_reset();
        c0 = cyc;
        for (int j = 0; j < 3; j++) begin
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs[u] !== exp_vec(u)) begin
                    errors++; $display("FAIL offset dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int b = 7; b >= 0; b--) begin
                cycle(wd[i][b], 1'($urandom), 1'($urandom), 1'($urandom));
                for (int u = 0; u < 2; u++) begin
                    checks++;
                    if (obs[u] !== exp_vec(u)) begin
                        errors++; $display("FAIL offset dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                    end
                end
                if (v8) begin vt.push_back(cyc); vo.push_back(out8); end
            end
        end
        checks++;
        if (vt.size() != 2) begin
            errors++; $display("FAIL offset_pulses got=%0d exp=2", vt.size());
        end else begin
            checks++;
            if (vt[0] - c0 != 19) begin errors++; $display("FAIL offset_first got=%0d exp=19", vt[0] - c0); end
            checks++;
            if ({vo[0], vo[1]} !== {8'hBC, 8'hA5}) begin errors++; $display("FAIL offset_words got=%h %h exp=bc a5", vo[0], vo[1]); end
        end
    endtask

    task automatic test_align_break();
        logic [7:0] wd [5];
        int nv, nl;
        wd = '{8'hBC, 8'h5A, 8'h00, 8'h5A, 8'h33};
        nv = 0; nl = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            for (int b = 7; b >= 0; b--) begin
                cycle(wd[i][b], 1'($urandom), 1'($urandom), 1'($urandom));
                for (int u = 0; u < 2; u++) begin
                    checks++;
                    if (obs[u] !== exp_vec(u)) begin
                        errors++; $display("FAIL break dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                    end
                end
                if (v8) nv++;
                if (l8) nl++;
            end
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL break_valid got=%0d exp=0", nv); end
        checks++;
        if (nl != 0) begin errors++; $display("FAIL break_locked got=%0d exp=0", nl); end
    endtask

    task automatic test_misaligned();
        logic [7:0] wd [6];
        bit qd [$];
        wd = '{8'hBC, 8'hBC, 8'h5A, 8'hBC, 8'hBC, 8'h5A};
        for (int i = 0; i < 6; i++) begin
            if (i == 3) for (int z = 0; z < 4; z++) qd.push_back(1'b0);
            for (int b = 7; b >= 0; b--) qd.push_back(wd[i][b]);
        end
        do_reset();
        for (int i = 0; i < qd.size(); i++) begin
            cycle(qd[i], 1'($urandom), 1'($urandom), 1'($urandom));
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs[u] !== exp_vec(u)) begin
                    errors++; $display("FAIL misalign dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                end
            end
            if (i == 34) begin
                checks++;
                if (l8 !== 1'b1) begin errors++; $display("FAIL misalign_before got=%b exp=1", l8); end
            end
            if (i == 35) begin
                checks++;
                if ({l8, v8} !== 2'b00) begin errors++; $display("FAIL misalign_drop got=%b%b exp=00", l8, v8); end
            end
            if (i == 43) begin
                checks++;
                if ({l8, v8, out8} !== {2'b11, 8'hBC}) begin
                    errors++; $display("FAIL misalign_relock got=%b%b %h exp=11 bc", l8, v8, out8);
                end
            end
        end
    endtask

    task automatic test_reset_midlock();
        logic [7:0] wd [4];
        int nv;
        wd = '{8'hBC, 8'hBC, 8'h5A, 8'h5A};
        nv = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int b = 7; b >= ((i == 3) ? 5 : 0); b--) begin
                cycle(wd[i][b], 1'b1, 1'($urandom), 1'($urandom));
                for (int u = 0; u < 2; u++) begin
                    checks++;
                    if (obs[u] !== exp_vec(u)) begin
                        errors++; $display("FAIL midlock dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                    end
                end
            end
        end
        checks++;
        if (l8 !== 1'b1) begin errors++; $display("FAIL midlock_locked got=%b exp=1", l8); end
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (obs[u] !== 35'd0) begin
                errors++; $display("FAIL midlock_async dut%0d got=%h exp=0", u, obs[u]);
            end
        end
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int b = 7; b >= 0; b--) begin
                cycle(wd[i][b], 1'($urandom), 1'($urandom), 1'($urandom));
                for (int u = 0; u < 2; u++) begin
                    checks++;
                    if (obs[u] !== exp_vec(u)) begin
                        errors++; $display("FAIL midlock_re dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                    end
                end
                if (i == 0 && v8) nv++;
                if (i == 0 && b == 0) begin
                    checks++;
                    if ({l8, nv != 0} !== 2'b00) begin errors++; $display("FAIL midlock_one_com got=%b/%0d exp=0/0", l8, nv); end
                end
                if (i == 1 && b == 0) begin
                    checks++;
                    if ({l8, v8, out8} !== {2'b11, 8'hBC}) begin
                        errors++; $display("FAIL midlock_relock got=%b%b %h exp=11 bc", l8, v8, out8);
                    end
                end
            end
        end
    endtask

    task automatic test_width10();
        logic [9:0] wd [4];
        bit wk [4];
        int vt [$];
        logic [9:0] vo [$];
        bit vk [$];
        int c0;
        wd = '{10'h17C, 10'h155, 10'h0F0, 10'h2AA};
        wk = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            for (int b = 9; b >= 0; b--) begin
                cycle(1'($urandom), 1'($urandom), wd[i][b], wk[i]);
                for (int u = 0; u < 2; u++) begin
                    checks++;
                    if (obs[u] !== exp_vec(u)) begin
                        errors++; $display("FAIL w10 dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                    end
                end
                if (v10) begin vt.push_back(cyc); vo.push_back(out10); vk.push_back(dk10); end
                if (i == 0 && b == 0) begin
                    checks++;
                    if ({l10, v10, out10, dk10} !== {2'b11, 10'h17C, 1'b1}) begin
                        errors++; $display("FAIL w10_lock got=%b%b %h/%b exp=11 17c/1", l10, v10, out10, dk10);
                    end
                end
            end
        end
        checks++;
        if (vt.size() != 4) begin
            errors++; $display("FAIL w10_pulses got=%0d exp=4", vt.size());
        end else begin
            checks++;
            if (vt[0] - c0 != 10) begin errors++; $display("FAIL w10_first got=%0d exp=10", vt[0] - c0); end
            for (int j = 1; j < 4; j++) begin
                checks++;
                if (vt[j] - vt[j-1] != 10 || vo[j] !== wd[j] || vk[j] !== wk[j]) begin
                    errors++; $display("FAIL w10_word%0d got=%0d %h/%b exp=10 %h/%b", j, vt[j] - vt[j-1], vo[j], vk[j], wd[j], wk[j]);
                end
            end
        end
    endtask

    task automatic test_random();
        int rem [2];
        int word [2];
        bit kk [2];
        bit bt [2];
        int w, sel;
        rem = '{0, 0};
        word = '{0, 0};
        kk = '{1'b0, 1'b0};
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int u = 0; u < 2; u++) begin
                w = (u == 1) ? 10 : 8;
                if (rem[u] == 0) begin
                    sel = $urandom_range(0, 3);
                    kk[u] = 1'($urandom);
                    if (sel <= 1) begin
                        word[u] = (u == 1) ? 'h17C : 'hBC; rem[u] = w;
                    end else if (sel == 2) begin
                        word[u] = int'($urandom) & ((1 << w) - 1); rem[u] = w;
                    end else begin
                        rem[u] = $urandom_range(1, w - 1); word[u] = int'($urandom);
                    end
                end
                bt[u] = 1'((word[u] >> (rem[u] - 1)) & 1);
                rem[u]--;
            end
            cycle(bt[0], kk[0], bt[1], kk[1]);
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs[u] !== exp_vec(u)) begin
                    errors++; $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", u, cyc, obs[u], exp_vec(u));
                end
            end
        end
    endtask

    initial begin
        reset_L = 1'b0;
        d8 = 1'b0; k8 = 1'b0; d10 = 1'b0; k10 = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_offset();
        test_align_break();
        test_misaligned();
        test_reset_midlock();
        test_width10();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deserializador_sync.md
DESERIALIZADOR_SYNC -- requirements
Module: deserializador_sync

Interface
REQ-001 Parameter WIDTH, default 8: deserialised word width in bits; legal range 4..32.
REQ-002 Parameter COM_CHAR, default 8'hBC (WIDTH bits): comma pattern used for word alignment.
REQ-003 Parameter LOCK_COUNT, default 2: consecutive aligned COM words required to declare lock; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_L  input  1  reset, asynchronous and active-low.
REQ-006 data  input  1  serial bit stream, MSB of each word first, one bit per clk.
REQ-007 DK  input  1  data/control flag, sampled on the clk edge that captures a word's last bit.
REQ-008 out  output  WIDTH  last aligned word, registered.
REQ-009 out_DK  output  1  DK value captured with out, registered.
REQ-010 valid  output  1  one-cycle strobe; out/out_DK updated on this edge.
REQ-011 locked  output  1  high while in state LOCKED.

Function
REQ-012 Shift register sr (WIDTH bits) SHALL shift left each clk, data entering at bit 0; next-word value nw = {sr[WIDTH-2:0], data}.
REQ-013 Bit counter bcnt (ceil(log2 WIDTH) bits) SHALL count 0..WIDTH-1 and wrap to 0; boundary = (bcnt == WIDTH-1).
REQ-014 State machine SHALL have three states: HUNT, ALIGN, LOCKED.
REQ-015 HUNT: on any edge where nw == COM_CHAR, bcnt SHALL load 0, ccnt SHALL load 1, next state ALIGN (LOCKED directly if LOCK_COUNT == 1); bcnt free-runs otherwise.
REQ-016 ALIGN: at boundary, nw == COM_CHAR increments ccnt; when ccnt reaches LOCK_COUNT, next state LOCKED; any non-COM word at boundary returns to HUNT with ccnt = 0.
REQ-017 ALIGN: nw == COM_CHAR off-boundary SHALL restart alignment (bcnt = 0, ccnt = 1, remain ALIGN).
REQ-018 LOCKED: at every boundary, out <= nw, out_DK <= DK, valid = 1 for that cycle only; COM words are emitted like any other word.
REQ-019 The boundary edge completing the LOCK_COUNT-th COM SHALL also emit that COM (valid = 1) as the first locked word.
REQ-020 LOCKED: nw == COM_CHAR off-boundary (misaligned comma) SHALL drop lock: no valid that edge, bcnt = 0, ccnt = 1, next state ALIGN, locked low from next cycle.
REQ-021 valid SHALL never assert outside LOCKED or off-boundary; out/out_DK hold value between strobes.
REQ-022 ccnt SHALL saturate at LOCK_COUNT; no wrap.
REQ-023 Latency: out reflects a word on the same edge that samples its last bit (0 cycles after last bit).

Reset
REQ-024 reset_L low SHALL immediately force: sr = 0, bcnt = 0, ccnt = 0, state HUNT, out = 0, out_DK = 0, valid = 0, locked = 0.
REQ-025 Reset asserted mid-word or mid-lock SHALL discard partial word; no valid until full re-lock after release.
REQ-026 First edge after reset_L rises SHALL sample data normally.

Structure
REQ-027 Shared package serdes_pkg SHALL hold state encodings (HUNT/ALIGN/LOCKED) and 8-bit K-character constants COM, SKP, IDL, FTS, STP, SDP, END, EDB.
REQ-028 One sub-module, detector_com (WIDTH, COM_CHAR), SHALL compute the combinational comma match on nw; all remaining logic stays in deserializador_sync.

Verification (WIDTH=8, LOCK_COUNT=2, COM_CHAR=8'hBC)
REQ-029 Stream BC, BC, 5A (DK 1,1,0) from reset -> locked high after 2nd BC; valid pulses with out=BC/out_DK=1 then out=5A/out_DK=0, exactly 8 clk apart.
REQ-030 3 junk bits then BC, BC, A5 -> alignment found at bit offset 3; out=BC then A5; no valid before lock.
REQ-031 BC, 5A (ALIGN broken) -> back to HUNT, valid never asserts, locked stays 0.
REQ-032 Locked stream, then BC injected 4 bits off-boundary -> locked falls, no valid that edge; next aligned BC relocks and emits BC.
REQ-033 reset_L pulsed low mid-word while locked -> all outputs 0 asynchronously; re-lock requires 2 fresh COMs.
REQ-034 WIDTH=10, COM_CHAR=10'h17C, LOCK_COUNT=1 -> single 17C locks and is emitted; valid period 10 clk.
